// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core front end: datapath width, the NOP
// encoding presented to decode when no instruction is valid, the default
// reset PC, the fetch-stage state encoding and small PC helper functions.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    // Fetch-stage states; explicit codes keep the encoding stable for
    // anything that probes the state register.
    typedef enum logic [2:0] {
        IF_IDLE = 3'd0,
        IF_REQ  = 3'd1,
        IF_WAIT = 3'd2,
        IF_HOLD = 3'd3,
        IF_DROP = 3'd4
    } ifetch_state_e;

    // Force a byte address onto a 4-byte word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // True when an address is not word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_pc.sv
// -----------------------------------------------------------------------------
// ifetch_pc
// Program counter register with next-PC selection for the fetch stage.
//   clk, rst_n       : clock, asynchronous active-low reset
//   advance_i        : step the PC to the next sequential word (+4, wraps)
//   redirect_i       : load the redirect target (wins over advance_i)
//   redirect_pc_i    : redirect target; low two bits are cleared on load
//   pc_o             : current PC (registered)
//   misalign_o       : one-cycle flag, registered, set after a redirect whose
//                      target had non-zero low bits
// -----------------------------------------------------------------------------
module ifetch_pc
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;
    logic            misalign_d;
    logic            misalign_q;

    // Next-PC select: redirect beats sequential advance, otherwise hold.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (redirect_i) begin
            pc_d       = align_word(redirect_pc_i);
            misalign_d = is_misaligned(redirect_pc_i);
        end else if (advance_i) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and misalign flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign misalign_o = misalign_q;

endmodule

// File: rtl/ifetch_stage.sv
// -----------------------------------------------------------------------------
// ifetch_stage
// Instruction fetch: owns the PC, issues one word read at a time and holds the
// returned instruction (with its PC) until decode accepts it. Redirects cancel
// in-flight work; a response to a cancelled request is drained before the
// next request so that at most one request is ever outstanding.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_req, imem_addr         : read request pulse and word address (= PC)
//   imem_rvalid, imem_rdata     : read response
//   redirect_valid, redirect_pc : taken branch/jump target
//   inst_ready                  : decode accepts the held instruction
//   inst_valid, inst, inst_pc   : registered instruction to decode (NOP when
//                                 not valid)
//   misalign                    : pulse after a redirect to a non-word target
// -----------------------------------------------------------------------------
module ifetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            inst_ready,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign
);

    ifetch_state_e   state_q;
    ifetch_state_e   state_d;
    logic            inst_valid_q;
    logic            inst_valid_d;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_d;
    logic [XLEN-1:0] inst_pc_q;
    logic [XLEN-1:0] inst_pc_d;
    logic [XLEN-1:0] pc_s;
    logic            redirect_en_s;
    logic            advance_s;

    // A redirect seen before the first request has been issued is ignored.
    assign redirect_en_s = redirect_valid & (state_q != IF_IDLE);
    // Sequential advance only when decode consumes the held instruction.
    assign advance_s     = (state_q == IF_HOLD) & inst_ready & ~redirect_valid;

    ifetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .advance_i     (advance_s),
        .redirect_i    (redirect_en_s),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc_s),
        .misalign_o    (misalign)
    );

    // Fetch FSM and next values of the decode-facing instruction registers.
    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        case (state_q)
            IF_IDLE: begin
                state_d = IF_REQ;
            end
            IF_REQ: begin
                // The request has already left; a redirect must drain it.
                state_d = redirect_valid ? IF_DROP : IF_WAIT;
            end
            IF_WAIT: begin
                if (redirect_valid) begin
                    // Data arriving with the redirect is stale; if it is here
                    // already nothing is left to drain.
                    state_d = imem_rvalid ? IF_REQ : IF_DROP;
                end else if (imem_rvalid) begin
                    state_d      = IF_HOLD;
                    inst_valid_d = 1'b1;
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_s;
                end else begin
                    state_d = IF_WAIT;
                end
            end
            IF_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    state_d      = IF_REQ;
                    inst_valid_d = 1'b0;
                    inst_d       = NOP_INST;
                end else begin
                    state_d = IF_HOLD;
                end
            end
            IF_DROP: begin
                state_d = imem_rvalid ? IF_REQ : IF_DROP;
            end
            default: begin
                state_d      = IF_IDLE;
                inst_valid_d = 1'b0;
                inst_d       = NOP_INST;
            end
        endcase
        if (redirect_en_s) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
        end else begin
            inst_valid_d = inst_valid_d;
        end
    end

    // State and instruction output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IF_IDLE;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req   = (state_q == IF_REQ);
    assign imem_addr  = pc_s;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;
    import riscv_pkg::*;

    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, a_req, a_rvalid, a_redir, a_ready, a_valid, a_mis;
    logic [31:0] a_addr, a_rdata, a_rpc, a_inst, a_ipc;
    logic        rst_b_n, b_req, b_rvalid, b_redir, b_ready, b_valid, b_mis;
    logic [31:0] b_addr, b_rdata, b_rpc, b_inst, b_ipc;

    ifetch_stage u_dut_a (
        .clk(clk), .rst_n(rst_n), .imem_req(a_req), .imem_addr(a_addr),
        .imem_rvalid(a_rvalid), .imem_rdata(a_rdata), .redirect_valid(a_redir),
        .redirect_pc(a_rpc), .inst_ready(a_ready), .inst_valid(a_valid),
        .inst(a_inst), .inst_pc(a_ipc), .misalign(a_mis)
    );

    ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
        .clk(clk), .rst_n(rst_b_n), .imem_req(b_req), .imem_addr(b_addr),
        .imem_rvalid(b_rvalid), .imem_rdata(b_rdata), .redirect_valid(b_redir),
        .redirect_pc(b_rpc), .inst_ready(b_ready), .inst_valid(b_valid),
        .inst(b_inst), .inst_pc(b_ipc), .misalign(b_mis)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Compare one cycle of outputs; inst_pc only matters while valid.
    task automatic chk_out(input string tag,
                           input logic r, input logic [31:0] ad, input logic v,
                           input logic [31:0] in, input logic [31:0] ip, input logic m,
                           input logic er, input logic [31:0] ead, input logic ev,
                           input logic [31:0] ein, input logic [31:0] eip, input logic em);
        chk({tag, " imem_req"},   {31'd0, r}, {31'd0, er});
        chk({tag, " imem_addr"},  ad, ead);
        chk({tag, " inst_valid"}, {31'd0, v}, {31'd0, ev});
        chk({tag, " inst"},       in, ein);
        chk({tag, " misalign"},   {31'd0, m}, {31'd0, em});
        if (ev) chk({tag, " inst_pc"}, ip, eip);
    endtask

    task automatic chk_a(input string tag, input logic er, input logic [31:0] ead, input logic ev,
                         input logic [31:0] ein, input logic [31:0] eip, input logic em);
        chk_out(tag, a_req, a_addr, a_valid, a_inst, a_ipc, a_mis, er, ead, ev, ein, eip, em);
    endtask

    task automatic chk_b(input string tag, input logic er, input logic [31:0] ead, input logic ev,
                         input logic [31:0] ein, input logic [31:0] eip, input logic em);
        chk_out(tag, b_req, b_addr, b_valid, b_inst, b_ipc, b_mis, er, ead, ev, ein, eip, em);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rvalid;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_mis;
    } vec_t;

    localparam int NVEC = 32;
    vec_t tbl[NVEC];

    function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic rr,
                                input logic [31:0] rp, input logic rdy, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                                input logic [31:0] eip, input logic em);
        vec_t v;
        v.rvalid = rv; v.rdata = rd; v.redir = rr; v.rpc = rp; v.ready = rdy;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_ipc = eip; v.e_mis = em;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Tracks the fetch at transaction level: is a request due, is a response
    // outstanding, will that response be thrown away, is an instruction held.
    bit          m_started, m_need, m_out, m_stale, m_valid, m_mis;
    logic [31:0] m_pc, m_inst, m_ipc;

    task automatic model_reset(input logic [31:0] rpc);
        m_started = 1'b0; m_need = 1'b0; m_out = 1'b0; m_stale = 1'b0;
        m_valid = 1'b0; m_mis = 1'b0; m_pc = rpc; m_inst = NOPW; m_ipc = rpc;
    endtask

    task automatic model_step(input bit rv, input logic [31:0] rd, input bit rdir,
                              input logic [31:0] rpc, input bit rdy);
        bit nxt_need, redir, consumed;
        nxt_need = 1'b0;
        consumed = 1'b0;
        redir    = rdir && m_started;
        if (!m_started) begin
            m_started = 1'b1;
            nxt_need  = 1'b1;
        end else if (m_need) begin
            m_out   = 1'b1;
            m_stale = redir;
        end else if (m_out && rv) begin
            m_out = 1'b0;
            if (m_stale || redir) nxt_need = 1'b1;
            else begin
                m_valid = 1'b1; m_inst = rd; m_ipc = m_pc;
            end
        end else if (m_out) begin
            if (redir) m_stale = 1'b1;
        end else if (m_valid) begin
            if (redir || rdy) begin
                m_valid = 1'b0; m_inst = NOPW; nxt_need = 1'b1; consumed = !redir;
            end
        end
        m_mis = redir && (rpc[1:0] != 2'b00);
        if (redir) begin
            m_pc = rpc & ~32'h0000_0003;
            m_valid = 1'b0;
            m_inst = NOPW;
        end else if (consumed) begin
            m_pc = m_pc + 32'd4;
        end
        m_need = nxt_need;
    endtask

    initial begin
        int resp_at;
        logic [31:0] resp_addr;

        tbl[0]  = mk(0, 32'h0,         0, 32'h0,   0, 0, 32'h0,   0, NOPW,          32'h0,   0);
        tbl[1]  = mk(0, 32'h0,         0, 32'h0,   0, 1, 32'h0,   0, NOPW,          32'h0,   0);
        tbl[2]  = mk(1, 32'hFFC1_0093, 0, 32'h0,   0, 0, 32'h0,   0, NOPW,          32'h0,   0);
        tbl[3]  = mk(0, 32'h0,         0, 32'h0,   1, 0, 32'h0,   1, 32'hFFC1_0093, 32'h0,   0);
        tbl[4]  = mk(0, 32'h0,         0, 32'h0,   0, 1, 32'h4,   0, NOPW,          32'h0,   0);
        tbl[5]  = mk(1, 32'hFE11_2C23, 0, 32'h0,   0, 0, 32'h4,   0, NOPW,          32'h0,   0);
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(0, 32'h0,      0, 32'h0,   0, 0, 32'h4,   1, 32'hFE11_2C23, 32'h4,   0);
        tbl[11] = mk(0, 32'h0,         0, 32'h0,   1, 0, 32'h4,   1, 32'hFE11_2C23, 32'h4,   0);
        tbl[12] = mk(0, 32'h0,         0, 32'h0,   0, 1, 32'h8,   0, NOPW,          32'h0,   0);
        tbl[13] = mk(0, 32'h0,         1, 32'h100, 0, 0, 32'h8,   0, NOPW,          32'h0,   0);
        tbl[14] = mk(0, 32'h0,         0, 32'h0,   0, 0, 32'h100, 0, NOPW,          32'h0,   0);
        tbl[15] = mk(1, 32'hDEAD_BEEF, 0, 32'h0,   0, 0, 32'h100, 0, NOPW,          32'h0,   0);
        tbl[16] = mk(0, 32'h0,         0, 32'h0,   0, 1, 32'h100, 0, NOPW,          32'h0,   0);
        tbl[17] = mk(1, 32'hCAFE_F00D, 1, 32'h200, 0, 0, 32'h100, 0, NOPW,          32'h0,   0);
        tbl[18] = mk(0, 32'h0,         0, 32'h0,   0, 1, 32'h200, 0, NOPW,          32'h0,   0);
        tbl[19] = mk(1, 32'h0050_0093, 0, 32'h0,   0, 0, 32'h200, 0, NOPW,          32'h0,   0);
        tbl[20] = mk(0, 32'h0,         1, 32'h103, 1, 0, 32'h200, 1, 32'h0050_0093, 32'h200, 0);
        tbl[21] = mk(0, 32'h0,         0, 32'h0,   0, 1, 32'h100, 0, NOPW,          32'h0,   1);
        tbl[22] = mk(1, 32'h1234_5678, 0, 32'h0,   0, 0, 32'h100, 0, NOPW,          32'h0,   0);
        tbl[23] = mk(0, 32'h0,         0, 32'h0,   1, 0, 32'h100, 1, 32'h1234_5678, 32'h100, 0);
        tbl[24] = mk(1, 32'hBAD0_BAD0, 0, 32'h0,   0, 1, 32'h104, 0, NOPW,          32'h0,   0);
        tbl[25] = mk(0, 32'h0,         0, 32'h0,   0, 0, 32'h104, 0, NOPW,          32'h0,   0);
        tbl[26] = mk(1, 32'h1111_1111, 0, 32'h0,   0, 0, 32'h104, 0, NOPW,          32'h0,   0);
        tbl[27] = mk(1, 32'h2222_2222, 0, 32'h0,   0, 0, 32'h104, 1, 32'h1111_1111, 32'h104, 0);
        tbl[28] = mk(0, 32'h0,         0, 32'h0,   1, 0, 32'h104, 1, 32'h1111_1111, 32'h104, 0);
        tbl[29] = mk(0, 32'h0,         1, 32'h40,  0, 1, 32'h108, 0, NOPW,          32'h0,   0);
        tbl[30] = mk(1, 32'h3333_3333, 0, 32'h0,   0, 0, 32'h40,  0, NOPW,          32'h0,   0);
        tbl[31] = mk(0, 32'h0,         0, 32'h0,   0, 1, 32'h40,  0, NOPW,          32'h0,   0);

        rst_n = 1'b0; a_rvalid = 1'b0; a_rdata = 32'h0; a_redir = 1'b0; a_rpc = 32'h0; a_ready = 1'b0;
        rst_b_n = 1'b0; b_rvalid = 1'b0; b_rdata = 32'h0; b_redir = 1'b0; b_rpc = 32'h0; b_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table: row i describes the cycle i after reset release.
        for (int i = 0; i < NVEC; i++) begin
            a_rvalid = tbl[i].rvalid; a_rdata = tbl[i].rdata; a_redir = tbl[i].redir;
            a_rpc = tbl[i].rpc; a_ready = tbl[i].ready;
            chk_a($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                  tbl[i].e_inst, tbl[i].e_ipc, tbl[i].e_mis);
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset while waiting for a response.
        a_rvalid = 1'b0; a_redir = 1'b0; a_ready = 1'b0;
        chk_a("pre_rst", 0, 32'h40, 0, NOPW, 32'h0, 0);
        rst_n = 1'b0;
        #1;
        chk_a("async_rst", 0, 32'h0, 0, NOPW, 32'h0, 0);
        chk("async_rst inst_pc", a_ipc, 32'h0);
        @(negedge clk);
        a_rvalid = 1'b1; a_rdata = 32'h7777_7777;
        @(negedge clk);
        rst_n = 1'b1;
        chk_a("post_rst idle", 0, 32'h0, 0, NOPW, 32'h0, 0);
        @(posedge clk); @(negedge clk);
        a_rvalid = 1'b0;
        chk_a("post_rst req", 1, 32'h0, 0, NOPW, 32'h0, 0);
        @(posedge clk); @(negedge clk);
        chk_a("post_rst wait", 0, 32'h0, 0, NOPW, 32'h0, 0);

        // Instance with RESET_PC at the top of the address space: PC wraps.
        @(negedge clk);
        rst_b_n = 1'b1;
        chk_b("b idle", 0, 32'hFFFF_FFFC, 0, NOPW, 32'h0, 0);
        @(posedge clk); @(negedge clk);
        chk_b("b req0", 1, 32'hFFFF_FFFC, 0, NOPW, 32'h0, 0);
        @(posedge clk); @(negedge clk);
        b_rvalid = 1'b1; b_rdata = 32'h1357_9BDF;
        chk_b("b wait", 0, 32'hFFFF_FFFC, 0, NOPW, 32'h0, 0);
        @(posedge clk); @(negedge clk);
        b_rvalid = 1'b0; b_ready = 1'b1;
        chk_b("b hold", 0, 32'hFFFF_FFFC, 1, 32'h1357_9BDF, 32'hFFFF_FFFC, 0);
        @(posedge clk); @(negedge clk);
        b_ready = 1'b0;
        chk_b("b req1 wrap", 1, 32'h0, 0, NOPW, 32'h0, 0);

        // Randomized traffic against the reference model.
        a_rvalid = 1'b0; a_redir = 1'b0; a_ready = 1'b0;
        rst_n = 1'b0;
        model_reset(32'h0);
        resp_at = -1;
        resp_addr = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            chk_a($sformatf("rnd%0d", c), m_need, m_pc, m_valid, m_inst, m_ipc, m_mis);
            if (a_req) begin
                resp_at = c + int'($urandom_range(3, 1));
                resp_addr = a_addr;
            end
            a_rvalid = 1'b0;
            a_rdata = $urandom;
            if (c == resp_at) begin
                a_rvalid = 1'b1;
                a_rdata = resp_addr ^ 32'h5A5A_0F0F;
            end else if (!m_out && resp_at < c && $urandom_range(7, 0) == 0) begin
                a_rvalid = 1'b1;
            end
            a_redir = ($urandom_range(9, 0) == 0);
            case ($urandom_range(3, 0))
                0: a_rpc = $urandom;
                1: a_rpc = 32'hFFFF_FFF0 | {28'd0, 4'($urandom_range(15, 0))};
                2: a_rpc = {24'd0, 8'($urandom_range(255, 0))};
                default: a_rpc = $urandom & 32'h0000_FFFC;
            endcase
            a_ready = ($urandom_range(2, 0) != 0);
            @(posedge clk);
            model_step(a_rvalid, a_rdata, a_redir, a_rpc, a_ready);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
